main_mem_ctrl: RTL and testbench

//  Responder end of the cache<->memory request/response protocol. Accepts block requests from the

---
 rtl/main_mem_ctrl_if.sv | 45 ++++
 rtl/main_mem_ctrl.sv | 148 ++++++++++++++
 tb/tb_main_mem_ctrl.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_mem_ctrl_if.sv
// Cache <-> main-memory request/response bundle.
// The icache side carries read requests only. The dcache side carries reads and byte-masked writes.
// Handshake: a request transfers on a rising clock edge where req_valid && req_ready are both high.
//   The requester holds valid and all request fields stable until that edge.
//   resp_valid is a single-cycle pulse with no back-pressure.
//   resp_block_data is all zero whenever resp_valid is low.
interface main_mem_ctrl_if #(
    parameter int BLOCK_ADDR_W = 8,
    parameter int BLOCK_BYTES  = 8,
    parameter int ADDR_W       = 32
);
    localparam int BLOCK_W = BLOCK_BYTES * 8;

    logic                    icache_req_valid;
    logic [BLOCK_ADDR_W-1:0] icache_req_block_addr;
    logic                    icache_req_ready;
    logic                    icache_resp_valid;
    logic [BLOCK_W-1:0]      icache_resp_block_data;

    logic                    dcache_req_valid;
    logic                    dcache_req_type;       // 0 read, 1 write
    logic [BLOCK_ADDR_W-1:0] dcache_req_block_addr;
    logic [BLOCK_W-1:0]      dcache_req_block_data;
    logic [1:0]              dcache_req_width;      // 0 byte, 1 halfword, 2 word
    logic [ADDR_W-1:0]       dcache_req_addr;
    logic                    dcache_req_ready;
    logic                    dcache_resp_valid;
    logic [BLOCK_W-1:0]      dcache_resp_block_data;

    modport master (
        output icache_req_valid, icache_req_block_addr,
        input  icache_req_ready, icache_resp_valid, icache_resp_block_data,
        output dcache_req_valid, dcache_req_type, dcache_req_block_addr,
        output dcache_req_block_data, dcache_req_width, dcache_req_addr,
        input  dcache_req_ready, dcache_resp_valid, dcache_resp_block_data
    );

    modport slave (
        input  icache_req_valid, icache_req_block_addr,
        output icache_req_ready, icache_resp_valid, icache_resp_block_data,
        input  dcache_req_valid, dcache_req_type, dcache_req_block_addr,
        input  dcache_req_block_data, dcache_req_width, dcache_req_addr,
        output dcache_req_ready, dcache_resp_valid, dcache_resp_block_data
    );
endinterface

// File: rtl/main_mem_ctrl.sv
// Main-memory responder. It arbitrates icache and dcache requests, with the icache always winning.
// It serves one transaction at a time from an internal block array.
// Each response comes MEM_LATENCY cycles after the accept and is a one-cycle pulse to the owning cache.
module main_mem_ctrl #(
    parameter int MEM_LATENCY  = 4,
    parameter int BLOCK_ADDR_W = 8,
    parameter int BLOCK_BYTES  = 8,
    parameter int ADDR_W       = 32,
    parameter int N_BLOCKS     = 2 ** BLOCK_ADDR_W
) (
    input  logic             clk,
    input  logic             rst_aL,
    main_mem_ctrl_if.slave   bus,
    output logic [1:0]       dbg_state_o
);
    localparam int BLOCK_W = BLOCK_BYTES * 8;
    localparam int OFF_W   = $clog2(BLOCK_BYTES);
    localparam int CTR_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CTR_W-1:0]        ctr_q;
    logic                    owner_d_q;   // 1: dcache owns the transaction
    logic                    wr_q;
    logic [BLOCK_ADDR_W-1:0] blk_q;
    logic [BLOCK_W-1:0]      data_q;
    logic [1:0]              width_q;
    logic [OFF_W-1:0]        off_q;

    logic [BLOCK_W-1:0]      mem [N_BLOCKS];

    logic                    i_accept;
    logic                    d_accept;
    logic                    resp_active;
    logic [BLOCK_W-1:0]      cur_block;
    logic [BLOCK_W-1:0]      merged_d;
    logic                    unused_addr_bits;

    // Store size in bytes. An unused encoding is treated as a word.
    function automatic int nbytes_of(input logic [1:0] w);
        case (w)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    // Only the byte offset of the store address matters; the block address arrives separately.
    assign unused_addr_bits = ^bus.dcache_req_addr[ADDR_W-1:OFF_W];

    // Readys are raised only in IDLE. The dcache is held off whenever the icache is asking.
    assign bus.icache_req_ready = rst_aL && (state_q == S_IDLE);
    assign bus.dcache_req_ready = rst_aL && (state_q == S_IDLE) && !bus.icache_req_valid;
    assign i_accept = bus.icache_req_valid && bus.icache_req_ready;
    assign d_accept = bus.dcache_req_valid && bus.dcache_req_ready;

    // Merge the latched store bytes into the addressed block; reads just see the block.
    always_comb begin
        cur_block = mem[blk_q];
        merged_d  = cur_block;
        for (int b = 0; b < BLOCK_BYTES; b++) begin
            if (b >= int'(off_q) && b < int'(off_q) + nbytes_of(width_q)) begin
                merged_d[b*8 +: 8] = data_q[b*8 +: 8];
            end
        end
    end

    // The response pulse goes to the owner only. Data is forced to zero outside the pulse.
    assign resp_active                = rst_aL && (state_q == S_RESP);
    assign bus.icache_resp_valid      = resp_active && !owner_d_q;
    assign bus.dcache_resp_valid      = resp_active && owner_d_q;
    assign bus.icache_resp_block_data = bus.icache_resp_valid ? cur_block : '0;
    assign bus.dcache_resp_block_data = bus.dcache_resp_valid ? (wr_q ? merged_d : cur_block) : '0;
    assign dbg_state_o                = state_q;

    // Transaction FSM: it latches the winning request, counts down the latency, then pulses the response.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            state_q   <= S_IDLE;
            ctr_q     <= '0;
            owner_d_q <= 1'b0;
            wr_q      <= 1'b0;
            blk_q     <= '0;
            data_q    <= '0;
            width_q   <= '0;
            off_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_accept || d_accept) begin
                        owner_d_q <= !i_accept;
                        if (i_accept) begin
                            wr_q    <= 1'b0;
                            blk_q   <= bus.icache_req_block_addr;
                            data_q  <= '0;
                            width_q <= '0;
                            off_q   <= '0;
                        end else begin
                            wr_q    <= bus.dcache_req_type;
                            blk_q   <= bus.dcache_req_block_addr;
                            data_q  <= bus.dcache_req_block_data;
                            width_q <= bus.dcache_req_width;
                            off_q   <= bus.dcache_req_addr[OFF_W-1:0];
                        end
                        if (MEM_LATENCY == 1) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            ctr_q   <= CTR_W'(MEM_LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    ctr_q <= ctr_q - CTR_W'(1);
                    if (ctr_q == CTR_W'(1)) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Writes commit on the RESP edge. If reset is asserted at that edge, the write is dropped.
    // Reset never clears the array.
    always_ff @(posedge clk) begin
        if (rst_aL && state_q == S_RESP && owner_d_q && wr_q) begin
            mem[blk_q] <= merged_d;
        end
    end

    // A store must be naturally aligned within its block.
    always_ff @(posedge clk) begin
        if (rst_aL && d_accept && bus.dcache_req_type) begin
            assert ((int'(bus.dcache_req_addr[OFF_W-1:0]) % nbytes_of(bus.dcache_req_width)) == 0);
        end
    end
endmodule

// File: tb/tb_main_mem_ctrl.sv
// Bench for main_mem_ctrl. The main instance runs with 8-byte blocks and a latency of 4.
// A second instance runs with a latency of 1 to cover back-to-back throughput.
module tb_main_mem_ctrl;
    localparam int BA_W = 8;
    localparam int BB   = 8;
    localparam int AW   = 32;
    localparam int BW   = 64;
    localparam int LAT  = 4;

    logic clk = 1'b0;
    logic rst_aL = 1'b0;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state1;
    int errors = 0;
    int checks = 0;

    // Reference memory contents, indexed by block address.
    logic [BW-1:0] model_mem [int];

    main_mem_ctrl_if #(.BLOCK_ADDR_W(BA_W), .BLOCK_BYTES(BB), .ADDR_W(AW)) bus ();
    main_mem_ctrl_if #(.BLOCK_ADDR_W(BA_W), .BLOCK_BYTES(BB), .ADDR_W(AW)) bus1 ();

    main_mem_ctrl #(.MEM_LATENCY(LAT), .BLOCK_ADDR_W(BA_W), .BLOCK_BYTES(BB), .ADDR_W(AW)) dut (
        .clk(clk), .rst_aL(rst_aL), .bus(bus), .dbg_state_o(dbg_state)
    );
    main_mem_ctrl #(.MEM_LATENCY(1), .BLOCK_ADDR_W(BA_W), .BLOCK_BYTES(BB), .ADDR_W(AW)) dut1 (
        .clk(clk), .rst_aL(rst_aL), .bus(bus1), .dbg_state_o(dbg_state1)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic int nbytes_of(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    // Replace bytes [off, off+n) of old with the same lanes of d.
    function automatic logic [BW-1:0] model_merge(input logic [BW-1:0] old, input logic [BW-1:0] d,
                                                  input int off, input int n);
        logic [BW-1:0] r;
        r = old;
        for (int b = off; b < off + n; b++) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Driver: issue one request on the main instance and follow it to its response.
    // lat is the response cycle counted from the accept edge, or -1 if no response came.
    // bad counts protocol faults seen while busy: a ready high, a wrong-owner pulse,
    // non-zero idle data, or an accept that never happened.
    task automatic drive_txn(input bit is_d, input bit wr, input logic [BA_W-1:0] blk,
                             input int off, input logic [BW-1:0] d, input logic [1:0] w,
                             output int lat, output logic [BW-1:0] rd, output int bad);
        int waited;
        bit got;
        bad = 0;
        lat = -1;
        rd = '0;
        got = 0;
        @(negedge clk);
        if (is_d) begin
            bus.dcache_req_valid      = 1'b1;
            bus.dcache_req_type       = wr;
            bus.dcache_req_block_addr = blk;
            bus.dcache_req_block_data = d;
            bus.dcache_req_width      = w;
            bus.dcache_req_addr       = AW'(int'(blk) * BB + off);
        end else begin
            bus.icache_req_valid      = 1'b1;
            bus.icache_req_block_addr = blk;
        end
        waited = 0;
        #1;
        while (!(is_d ? bus.dcache_req_ready : bus.icache_req_ready) && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 20) bad += 100;
        @(negedge clk);
        bus.icache_req_valid = 1'b0;
        bus.dcache_req_valid = 1'b0;
        for (int c = 1; c <= 3 * LAT && !got; c++) begin
            #1;
            if (bus.icache_req_ready || bus.dcache_req_ready) bad++;
            if (is_d ? bus.icache_resp_valid : bus.dcache_resp_valid) bad++;
            if (is_d ? bus.dcache_resp_valid : bus.icache_resp_valid) begin
                lat = c;
                rd = is_d ? bus.dcache_resp_block_data : bus.icache_resp_block_data;
                got = 1;
            end else begin
                if ((is_d ? bus.dcache_resp_block_data : bus.icache_resp_block_data) !== '0) bad++;
                @(negedge clk);
            end
        end
    endtask

    // Driver: dcache store that also updates the reference model. exp is the expected merged block.
    task automatic dstore(input logic [BA_W-1:0] blk, input int off, input logic [BW-1:0] d,
                          input logic [1:0] w, output int lat, output logic [BW-1:0] rd,
                          output int bad, output logic [BW-1:0] exp);
        logic [BW-1:0] old;
        old = model_mem.exists(int'(blk)) ? model_mem[int'(blk)] : '0;
        exp = model_merge(old, d, off, nbytes_of(w));
        model_mem[int'(blk)] = exp;
        drive_txn(1'b1, 1'b1, blk, off, d, w, lat, rd, bad);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        bus.icache_req_valid = 1'b1;
        bus.dcache_req_valid = 1'b1;
        #1;
        checks++;
        if ({bus.icache_req_ready, bus.dcache_req_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_readys: got %b want 00", {bus.icache_req_ready, bus.dcache_req_ready});
        end
        checks++;
        if ({bus.icache_resp_valid, bus.dcache_resp_valid} !== 2'b00
            || bus.icache_resp_block_data !== '0 || bus.dcache_resp_block_data !== '0) begin
            errors++;
            $display("FAIL reset_resp: got valids %b want 00 with zero data",
                     {bus.icache_resp_valid, bus.dcache_resp_valid});
        end
        bus.icache_req_valid = 1'b0;
        bus.dcache_req_valid = 1'b0;
        @(negedge clk);
        rst_aL = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.icache_req_ready, bus.dcache_req_ready} !== 2'b11) begin
            errors++;
            $display("FAIL idle_readys: got %b want 11", {bus.icache_req_ready, bus.dcache_req_ready});
        end
        bus.icache_req_valid = 1'b1;
        #1;
        checks++;
        if ({bus.icache_req_ready, bus.dcache_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL priority_readys: got %b want 10", {bus.icache_req_ready, bus.dcache_req_ready});
        end
        bus.icache_req_valid = 1'b0;
    endtask

    // Preload block 0x10 with 0x1122334455667788 via two word stores, then read it through the icache.
    task automatic test_icache_read();
        int lat, bad;
        logic [BW-1:0] rd, exp;
        dstore(8'h10, 0, 64'h0000_0000_5566_7788, 2'd2, lat, rd, bad, exp);
        dstore(8'h10, 4, 64'h1122_3344_0000_0000, 2'd2, lat, rd, bad, exp);
        checks++;
        if (lat != LAT || bad != 0 || rd !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL preload_store: got lat=%0d bad=%0d data=%h want lat=%0d bad=0 data=%h",
                     lat, bad, rd, LAT, 64'h1122334455667788);
        end
        drive_txn(1'b0, 1'b0, 8'h10, 0, '0, 2'd0, lat, rd, bad);
        checks++;
        if (lat != LAT || bad != 0) begin
            errors++;
            $display("FAIL icache_timing: got lat=%0d bad=%0d want lat=%0d bad=0", lat, bad, LAT);
        end
        checks++;
        if (rd !== model_mem[16]) begin
            errors++;
            $display("FAIL icache_data: got %h want %h", rd, model_mem[16]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.icache_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_resp: got %b want 1", bus.icache_req_ready);
        end
    endtask

    // Both caches ask in the same cycle: the icache is served first and the dcache follows.
    task automatic test_priority();
        int lat, bad, i_at, d_acc, d_at;
        logic [BW-1:0] rd, exp, i_data, d_data;
        dstore(8'h11, 0, 64'hA5A5_A5A5_0102_0304, 2'd2, lat, rd, bad, exp);
        dstore(8'h11, 4, 64'h0506_0708_0000_0000, 2'd2, lat, rd, bad, exp);
        @(negedge clk);
        bus.icache_req_valid = 1'b1;
        bus.icache_req_block_addr = 8'h10;
        bus.dcache_req_valid = 1'b1;
        bus.dcache_req_type = 1'b0;
        bus.dcache_req_block_addr = 8'h11;
        #1;
        checks++;
        if ({bus.icache_req_ready, bus.dcache_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL both_valid_readys: got %b want 10", {bus.icache_req_ready, bus.dcache_req_ready});
        end
        @(negedge clk);
        bus.icache_req_valid = 1'b0;
        i_at = -1; d_acc = -1; d_at = -1;
        i_data = '0; d_data = '0;
        for (int c = 1; c <= 14; c++) begin
            #1;
            if (bus.icache_resp_valid && i_at < 0) begin i_at = c; i_data = bus.icache_resp_block_data; end
            if (bus.dcache_resp_valid && d_at < 0) begin d_at = c; d_data = bus.dcache_resp_block_data; end
            if (bus.dcache_req_ready && d_acc < 0) d_acc = c;
            @(negedge clk);
            if (d_acc >= 0) bus.dcache_req_valid = 1'b0;
        end
        bus.dcache_req_valid = 1'b0;
        checks++;
        if (i_at != LAT || d_acc != LAT + 1 || d_at != 2 * LAT + 1) begin
            errors++;
            $display("FAIL priority_timing: got i_resp=%0d d_accept=%0d d_resp=%0d want %0d %0d %0d",
                     i_at, d_acc, d_at, LAT, LAT + 1, 2 * LAT + 1);
        end
        checks++;
        if (i_data !== model_mem[16] || d_data !== model_mem[17]) begin
            errors++;
            $display("FAIL priority_data: got i=%h d=%h want i=%h d=%h", i_data, d_data,
                     model_mem[16], model_mem[17]);
        end
    endtask

    // Stores of word, byte and halfword size into block 0x10.
    task automatic test_store();
        int lat, bad;
        logic [BW-1:0] rd, exp;
        dstore(8'h10, 4, 64'hDEAD_BEEF_0000_0000, 2'd2, lat, rd, bad, exp);
        checks++;
        if (lat != LAT || bad != 0 || rd !== 64'hDEADBEEF55667788) begin
            errors++;
            $display("FAIL sw_resp: got lat=%0d bad=%0d data=%h want lat=%0d data=%h",
                     lat, bad, rd, LAT, 64'hDEADBEEF55667788);
        end
        drive_txn(1'b0, 1'b0, 8'h10, 0, '0, 2'd0, lat, rd, bad);
        checks++;
        if (rd !== 64'hDEADBEEF55667788) begin
            errors++;
            $display("FAIL sw_readback: got %h want %h", rd, 64'hDEADBEEF55667788);
        end
        dstore(8'h10, 1, 64'h0000_0000_0000_AA00, 2'd0, lat, rd, bad, exp);
        checks++;
        if (rd !== 64'hDEADBEEF5566AA88) begin
            errors++;
            $display("FAIL sb_resp: got %h want %h", rd, 64'hDEADBEEF5566AA88);
        end
        dstore(8'h10, 6, 64'h1234_0000_0000_0000, 2'd1, lat, rd, bad, exp);
        drive_txn(1'b1, 1'b0, 8'h10, 0, '0, 2'd0, lat, rd, bad);
        checks++;
        if (rd !== 64'h1234BEEF5566AA88 || lat != LAT) begin
            errors++;
            $display("FAIL sh_readback: got %h lat=%0d want %h lat=%0d", rd, lat, 64'h1234BEEF5566AA88, LAT);
        end
    endtask

    // Reset two cycles after a store is accepted: no response, and the block stays unchanged.
    task automatic test_reset_mid();
        int lat, bad, seen;
        logic [BW-1:0] rd;
        @(negedge clk);
        bus.dcache_req_valid = 1'b1;
        bus.dcache_req_type = 1'b1;
        bus.dcache_req_block_addr = 8'h10;
        bus.dcache_req_block_data = 64'h0000_0000_CAFE_F00D;
        bus.dcache_req_width = 2'd2;
        bus.dcache_req_addr = 32'h80;
        #1;
        seen = 0;
        for (int k = 0; k < 20 && !bus.dcache_req_ready; k++) begin @(negedge clk); #1; end
        @(negedge clk);
        bus.dcache_req_valid = 1'b0;
        @(negedge clk);
        rst_aL = 1'b0;
        #1;
        checks++;
        if ({bus.icache_req_ready, bus.dcache_req_ready, bus.icache_resp_valid, bus.dcache_resp_valid} !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b want 0000",
                     {bus.icache_req_ready, bus.dcache_req_ready, bus.icache_resp_valid, bus.dcache_resp_valid});
        end
        @(negedge clk);
        rst_aL = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus.dcache_resp_valid || bus.icache_resp_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL dropped_resp: got %0d pulses want 0", seen);
        end
        drive_txn(1'b1, 1'b0, 8'h10, 0, '0, 2'd0, lat, rd, bad);
        checks++;
        if (rd !== model_mem[16] || lat != LAT || bad != 0) begin
            errors++;
            $display("FAIL unmodified_after_reset: got %h lat=%0d want %h lat=%0d", rd, lat, model_mem[16], LAT);
        end
    endtask

    // Random mix of icache reads, dcache reads and aligned stores over eight blocks.
    task automatic test_random();
        int lat, bad, kind, n, off;
        logic [BW-1:0] rd, exp, d;
        logic [BA_W-1:0] blk;
        logic [1:0] w;
        for (int b = 0; b < 8; b++) begin
            d = {$urandom, $urandom};
            dstore(BA_W'(8'h20 + b), 0, d, 2'd2, lat, rd, bad, exp);
            dstore(BA_W'(8'h20 + b), 4, d, 2'd2, lat, rd, bad, exp);
        end
        for (int i = 0; i < 40; i++) begin
            blk = BA_W'(8'h20 + $urandom_range(0, 7));
            kind = $urandom_range(0, 2);
            if (kind == 2) begin
                w = 2'($urandom_range(0, 2));
                n = nbytes_of(w);
                off = $urandom_range(0, BB / n - 1) * n;
                d = {$urandom, $urandom};
                dstore(blk, off, d, w, lat, rd, bad, exp);
            end else begin
                exp = model_mem[int'(blk)];
                drive_txn(kind == 1, 1'b0, blk, 0, '0, 2'd0, lat, rd, bad);
            end
            checks++;
            if (lat != LAT || bad != 0) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got lat=%0d bad=%0d want lat=%0d bad=0", i, lat, bad, LAT);
            end
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("FAIL rand_data[%0d] kind=%0d blk=%h: got %h want %h", i, kind, blk, rd, exp);
            end
        end
    endtask

    // With a latency of 1, a held dcache read is accepted every second cycle.
    // Each accept gets its response on the following cycle.
    task automatic test_latency1();
        logic [BW-1:0] v;
        int acc_q[$];
        int resp_q[$];
        int bad_data;
        v = {$urandom, $urandom};
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            bus1.dcache_req_valid = 1'b1;
            bus1.dcache_req_type = 1'b1;
            bus1.dcache_req_block_addr = 8'h03;
            bus1.dcache_req_block_data = v;
            bus1.dcache_req_width = 2'd2;
            bus1.dcache_req_addr = AW'(3 * BB + h * 4);
            #1;
            for (int k = 0; k < 20 && !bus1.dcache_req_ready; k++) begin @(negedge clk); #1; end
            @(negedge clk);
            bus1.dcache_req_valid = 1'b0;
            #1;
            checks++;
            if (bus1.dcache_resp_valid !== 1'b1) begin
                errors++;
                $display("FAIL lat1_store_resp[%0d]: got %b want 1", h, bus1.dcache_resp_valid);
            end
        end
        @(negedge clk);
        bus1.dcache_req_valid = 1'b1;
        bus1.dcache_req_type = 1'b0;
        bad_data = 0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (bus1.dcache_req_ready) acc_q.push_back(c);
            if (bus1.dcache_resp_valid) begin
                resp_q.push_back(c);
                if (bus1.dcache_resp_block_data !== v) bad_data++;
            end
            @(negedge clk);
        end
        bus1.dcache_req_valid = 1'b0;
        checks++;
        if (acc_q.size() != 8 || resp_q.size() != 8) begin
            errors++;
            $display("FAIL lat1_throughput: got accepts=%0d resps=%0d want 8 8", acc_q.size(), resp_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (resp_q[i] != acc_q[i] + 1 || (i > 0 && acc_q[i] != acc_q[i-1] + 2)) begin
                    errors++;
                    $display("FAIL lat1_spacing[%0d]: got accept=%0d resp=%0d want resp=accept+1, accepts 2 apart",
                             i, acc_q[i], resp_q[i]);
                end
            end
        end
        checks++;
        if (bad_data != 0) begin
            errors++;
            $display("FAIL lat1_data: got %0d wrong blocks want 0 (block %h)", bad_data, v);
        end
    endtask

    initial begin
        bus.icache_req_valid = 1'b0;
        bus.icache_req_block_addr = '0;
        bus.dcache_req_valid = 1'b0;
        bus.dcache_req_type = 1'b0;
        bus.dcache_req_block_addr = '0;
        bus.dcache_req_block_data = '0;
        bus.dcache_req_width = '0;
        bus.dcache_req_addr = '0;
        bus1.icache_req_valid = 1'b0;
        bus1.icache_req_block_addr = '0;
        bus1.dcache_req_valid = 1'b0;
        bus1.dcache_req_type = 1'b0;
        bus1.dcache_req_block_addr = '0;
        bus1.dcache_req_block_data = '0;
        bus1.dcache_req_width = '0;
        bus1.dcache_req_addr = '0;
        test_reset();
        test_icache_read();
        test_priority();
        test_store();
        test_reset_mid();
        test_random();
        test_latency1();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
